// File: rtl/ctrl_branch_unit_if.sv
// Branch-unit bus: ID-stage branch op, EX-stage ALU flags, redirect outputs
// and RAS status.
// The ID side is valid-only: the unit samples valid_ID/br_op_ID/br_target_ID/
// prog_ctr_ID on every rising edge with no ready/backpressure. The decoder
// must honour flush_ID in the same cycle it is asserted.
interface ctrl_branch_unit_if #(
  parameter int PROG_CTR_WID = 10,
  parameter int RAS_DEPTH    = 4
);
  logic                               valid_ID;
  logic [2:0]                         br_op_ID;
  logic [PROG_CTR_WID-1:0]            br_target_ID;
  logic [PROG_CTR_WID-1:0]            prog_ctr_ID;
  logic                               zero_flag_EX;
  logic                               carry_flag_EX;
  logic                               branch_taken_EX;
  logic [PROG_CTR_WID-1:0]            nxt_prog_ctr_EX;
  logic                               flush_ID;
  logic [$clog2(RAS_DEPTH+1)-1:0]     ras_count;
  logic                               ras_underflow_err;

  // Pipeline side: drives ID ops and flags, observes redirect and status.
  modport master (
    output valid_ID, br_op_ID, br_target_ID, prog_ctr_ID,
           zero_flag_EX, carry_flag_EX,
    input  branch_taken_EX, nxt_prog_ctr_EX, flush_ID,
           ras_count, ras_underflow_err
  );

  // Branch unit side.
  modport slave (
    input  valid_ID, br_op_ID, br_target_ID, prog_ctr_ID,
           zero_flag_EX, carry_flag_EX,
    output branch_taken_EX, nxt_prog_ctr_EX, flush_ID,
           ras_count, ras_underflow_err
  );
endinterface

// File: rtl/ctrl_branch_unit.sv
// EX-stage branch resolution: latches the ID branch op, resolves it against
// ALU flags, keeps a circular return-address stack for CALL/RET and squashes
// wrong-path instructions after a taken branch.
module ctrl_branch_unit #(
  parameter int PROG_CTR_WID = 10,
  parameter int RAS_DEPTH    = 4,
  parameter int SQUASH_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  ctrl_branch_unit_if.slave  bus
);
  localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CNT_W = $clog2(RAS_DEPTH + 1);
  localparam int SQ_W  = (SQUASH_DEPTH > 1) ? $clog2(SQUASH_DEPTH + 1) : 1;

  localparam logic [2:0] OP_NONE = 3'b000;
  localparam logic [2:0] OP_JMP  = 3'b001;
  localparam logic [2:0] OP_BZ   = 3'b010;
  localparam logic [2:0] OP_BNZ  = 3'b011;
  localparam logic [2:0] OP_BC   = 3'b100;
  localparam logic [2:0] OP_BNC  = 3'b101;
  localparam logic [2:0] OP_CALL = 3'b110;
  localparam logic [2:0] OP_RET  = 3'b111;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);
  localparam logic [SQ_W-1:0]  SQ_LOAD  = SQ_W'(SQUASH_DEPTH - 1);

  // EX pipeline register
  logic                    valid_ex;
  logic [2:0]              op_ex;
  logic [PROG_CTR_WID-1:0] target_ex;
  logic [PROG_CTR_WID-1:0] pc_ex;

  // Squash window and return-address stack
  logic [SQ_W-1:0]         squash_cnt;
  logic [PROG_CTR_WID-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]        wp;
  logic [PTR_W-1:0]        top_idx;
  logic [CNT_W-1:0]        count;
  logic                    err;

  logic                    taken;
  logic [PROG_CTR_WID-1:0] nxt;
  logic                    squash;
  logic                    push;
  logic                    pop_ok;
  logic                    underflow;

  assign squash    = taken || (squash_cnt != '0);
  assign top_idx   = wp - PTR_W'(1);
  assign push      = valid_ex && (op_ex == OP_CALL);
  assign pop_ok    = valid_ex && (op_ex == OP_RET) && (count != '0);
  assign underflow = valid_ex && (op_ex == OP_RET) && (count == '0);

  // EX register: take the ID op, or a bubble while squashing wrong-path work
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_ex  <= 1'b0;
      op_ex     <= OP_NONE;
      target_ex <= '0;
      pc_ex     <= '0;
    end else if (squash) begin
      valid_ex  <= 1'b0;
      op_ex     <= OP_NONE;
      target_ex <= '0;
      pc_ex     <= '0;
    end else begin
      valid_ex  <= bus.valid_ID;
      op_ex     <= bus.br_op_ID;
      target_ex <= bus.br_target_ID;
      pc_ex     <= bus.prog_ctr_ID;
    end
  end

  // Resolve the EX op; flags only matter for the four conditional branches
  always_comb begin
    taken = 1'b0;
    nxt   = '0;
    if (valid_ex) begin
      case (op_ex)
        OP_JMP, OP_CALL: taken = 1'b1;
        OP_RET:          taken = 1'b1;
        OP_BZ:           taken = bus.zero_flag_EX;
        OP_BNZ:          taken = !bus.zero_flag_EX;
        OP_BC:           taken = bus.carry_flag_EX;
        OP_BNC:          taken = !bus.carry_flag_EX;
        default:         taken = 1'b0;
      endcase
      if (taken) begin
        if (op_ex == OP_RET) nxt = (count != '0) ? ras_mem[top_idx] : '0;
        else                 nxt = target_ex;
      end
    end
  end

  // Squash counter: reload on a taken branch, then count down to zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                 squash_cnt <= '0;
    else if (taken)             squash_cnt <= SQ_LOAD;
    else if (squash_cnt != '0)  squash_cnt <= squash_cnt - SQ_W'(1);
  end

  // Return-address stack: one push or pop per cycle, oldest entry lost on overflow
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp    <= '0;
      count <= '0;
      err   <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_mem[i] <= '0;
    end else if (push) begin
      ras_mem[wp] <= pc_ex + PROG_CTR_WID'(1);
      wp          <= wp + PTR_W'(1);
      if (count != CNT_FULL) count <= count + CNT_W'(1);
    end else if (pop_ok) begin
      wp    <= wp - PTR_W'(1);
      count <= count - CNT_W'(1);
    end else if (underflow) begin
      err <= 1'b1;
    end
  end

  // Outputs toward the program counter, decoder and status
  always_comb begin
    bus.branch_taken_EX   = taken;
    bus.nxt_prog_ctr_EX   = nxt;
    bus.flush_ID          = squash;
    bus.ras_count         = count;
    bus.ras_underflow_err = err;
  end
endmodule
